// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU.
// Opcodes, FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD    = 3'b000,
    SUB    = 3'b001,
    XOR    = 3'b010,
    RSVD   = 3'b011,
    SLL    = 3'b100,
    SRA    = 3'b101,
    ROR    = 3'b110,
    PADDSB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SHIFT,
    DONE
  } alu_state_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  function automatic logic is_shift(alu_op_e op);
    return (op == SLL) || (op == SRA) || (op == ROR);
  endfunction

endpackage

// File: rtl/alu_seq_sat_add.sv
// Saturating signed add/sub of W bits.
// Works one bit wider so overflow is a sign mismatch.
module sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] y_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic [W:0] a_x;
  logic [W:0] b_x;
  logic [W:0] r_x;

  assign a_x   = {a_i[W-1], a_i};
  assign b_x   = {b_i[W-1], b_i};
  assign r_x   = sub_i ? (a_x - b_x) : (a_x + b_x);
  assign ovf_o = r_x[W] ^ r_x[W-1];

  // Clamp toward the true sign held in the extra bit.
  always_comb begin
    y_o = r_x[W-1:0];
    if (ovf_o) y_o = r_x[W] ? MINV : MAXV;
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: saturating arith, lane add,
// iterative shifter and registered Z/V/N flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LANE       = 4,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       Opcode,
  input  logic [WIDTH-1:0] ALU_In1,
  input  logic [WIDTH-1:0] ALU_In2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             Error,
  output logic [2:0]       flags
);

  localparam int SW    = $clog2(WIDTH);
  localparam int LANES = WIDTH / LANE;
  localparam logic [SW-1:0] STEP = SW'(SHIFT_STEP);

  alu_state_e       state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [SW-1:0]    rem_q, rem_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [2:0]       flags_q, flags_d;

  alu_op_e          op_in;
  logic             is_idle;
  logic             accept;
  logic [WIDTH-1:0] as_y;
  logic             as_v;
  logic [WIDTH-1:0] padd_y;
  logic [LANES-1:0] unused_lane_v;

  alu_op_e          sh_op;
  logic [WIDTH-1:0] sh_src;
  logic [SW-1:0]    sh_rem;
  logic [SW-1:0]    sh_k;
  logic [SW-1:0]    sh_nrem;
  logic [2*WIDTH-1:0] ror_x;
  logic [WIDTH-1:0] sh_res;

  logic [WIDTH-1:0] ex_res;
  logic             load;
  logic [WIDTH-1:0] ld_res;
  logic             ld_err;
  logic             ld_arith;

  assign op_in    = alu_op_e'(Opcode);
  assign is_idle  = (state_q == IDLE);
  assign in_ready = is_idle && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  sat_add #(.W(WIDTH)) u_addsub (
    .a_i  (ALU_In1),
    .b_i  (ALU_In2),
    .sub_i(Opcode[0]),
    .y_o  (as_y),
    .ovf_o(as_v)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sat_add #(.W(LANE)) u_lane (
      .a_i  (ALU_In1[g*LANE +: LANE]),
      .b_i  (ALU_In2[g*LANE +: LANE]),
      .sub_i(1'b0),
      .y_o  (padd_y[g*LANE +: LANE]),
      .ovf_o(unused_lane_v[g])
    );
  end

  // The first step runs in the accept cycle.
  assign sh_op   = is_idle ? op_in : op_q;
  assign sh_src  = is_idle ? ALU_In1 : val_q;
  assign sh_rem  = is_idle ? ALU_In2[SW-1:0] : rem_q;
  assign sh_k    = (sh_rem < STEP) ? sh_rem : STEP;
  assign sh_nrem = sh_rem - sh_k;
  assign ror_x   = {sh_src, sh_src} >> sh_k;

  // One shift step of up to STEP bits.
  always_comb begin
    sh_res = ror_x[WIDTH-1:0];
    unique case (sh_op)
      SLL:     sh_res = sh_src << sh_k;
      SRA:     sh_res = $signed(sh_src) >>> sh_k;
      default: sh_res = ror_x[WIDTH-1:0];
    endcase
  end

  // Result of ops that finish in one cycle.
  always_comb begin
    ex_res = '0;
    unique case (op_in)
      ADD, SUB: ex_res = as_y;
      XOR:      ex_res = ALU_In1 ^ ALU_In2;
      RSVD:     ex_res = '0;
      PADDSB:   ex_res = padd_y;
      default:  ex_res = sh_res;
    endcase
  end

  // Sequencer: next state and output-load strobe.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    val_d    = val_q;
    rem_d    = rem_q;
    load     = 1'b0;
    ld_res   = ex_res;
    ld_err   = 1'b0;
    ld_arith = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift(op_in)) begin
            if (sh_nrem == '0) begin
              load    = 1'b1;
              ld_res  = sh_res;
              state_d = DONE;
            end else begin
              op_d    = op_in;
              val_d   = sh_res;
              rem_d   = sh_nrem;
              state_d = SHIFT;
            end
          end else begin
            load     = 1'b1;
            ld_res   = ex_res;
            ld_err   = (op_in == RSVD);
            ld_arith = (op_in == ADD) || (op_in == SUB);
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        val_d = sh_res;
        rem_d = sh_nrem;
        if (sh_nrem == '0) begin
          load    = 1'b1;
          ld_res  = sh_res;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One-entry output buffer and flag file.
  always_comb begin
    valid_d = valid_q && !out_ready;
    res_d   = res_q;
    err_d   = err_q;
    flags_d = flags_q;
    if (load) begin
      valid_d = 1'b1;
      res_d   = ld_res;
      err_d   = ld_err;
      if (!ld_err) begin
        flags_d[FLAG_Z] = (ld_res == '0);
        if (ld_arith) begin
          flags_d[FLAG_V] = as_v;
          flags_d[FLAG_N] = ld_res[WIDTH-1];
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= ADD;
      val_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      val_q   <= val_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      err_q   <= err_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = valid_q;
  assign ALU_Out   = res_q;
  assign Error     = err_q;
  assign flags     = flags_q;

endmodule
